// File: rtl/decode_flow_sequencer_pkg.sv
// Shared types and defaults for the decompressor flow sequencer.
// Holds the state encoding (also shown on the stage LEDs), the SRAM owner
// select and the default parameter values used by decode_flow_sequencer.
package seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_UART_RX = 3'd1,
      S_HAND_A  = 3'd2,
      S_M2      = 3'd3,
      S_HAND_B  = 3'd4,
      S_M1      = 3'd5
   } seq_state_t;

   typedef enum logic [1:0] {
      OWN_VGA  = 2'd0,
      OWN_UART = 2'd1,
      OWN_M2   = 2'd2,
      OWN_M1   = 2'd3
   } sram_owner_t;

   localparam int DEF_UART_TIMEOUT = 50000000;
   localparam int DEF_WD_CYCLES    = 67108863;
   localparam int DEF_ADDR_W       = 18;
   localparam int DEF_DATA_W       = 16;

   // Which requester owns the SRAM port in a given state; handovers fall to VGA.
   function automatic sram_owner_t owner_of(input seq_state_t st);
      sram_owner_t own;
      case (st)
         S_UART_RX: own = OWN_UART;
         S_M2:      own = OWN_M2;
         S_M1:      own = OWN_M1;
         default:   own = OWN_VGA;
      endcase
      return own;
   endfunction

endpackage

// File: rtl/decode_flow_sequencer_timer.sv
// seq_timer: loadable saturating up-counter with clear, enable and an
// equality flag against a compare value. The sequencer uses one instance for
// both the UART idle timeout and the milestone watchdog.
module seq_timer #(
   parameter int W = 26
) (
   input  logic         CLOCK_50_I,
   input  logic         resetn,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic [W-1:0] cmp_val_i,
   output logic [W-1:0] count_o,
   output logic         eq_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Clear beats load beats increment; the count sticks at all-ones.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = {W{1'b0}};
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign eq_o    = (count_q == cmp_val_i);

endmodule

// File: rtl/decode_flow_sequencer.sv
// decode_flow_sequencer: top-level scheduler of the image decompressor.
// Runs IDLE -> UART receive -> M2 -> M1 -> IDLE, lends the single SRAM port
// to one requester at a time with a read-only handover cycle between owners,
// and aborts a milestone that overruns its watchdog (sticky wd_error).
// Optional build macro STAGE_CYCLE_COUNT_EN adds the stage_cycles counter;
// without it stage_cycles reads 0.
module decode_flow_sequencer
   import seq_pkg::*;
#(
   parameter int UART_TIMEOUT = DEF_UART_TIMEOUT,
   parameter int WD_CYCLES    = DEF_WD_CYCLES,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W
) (
   input  logic              CLOCK_50_I,
   input  logic              resetn,
   input  logic              UART_RX_I,
   input  logic [ADDR_W-1:0] uart_sram_addr,
   input  logic [DATA_W-1:0] uart_sram_wdata,
   input  logic              uart_sram_we_n,
   output logic              uart_init,
   output logic              uart_enable,
   input  logic [ADDR_W-1:0] m2_sram_addr,
   input  logic [DATA_W-1:0] m2_sram_wdata,
   input  logic              m2_sram_we_n,
   input  logic              m2_done,
   output logic              m2_start,
   input  logic [ADDR_W-1:0] m1_sram_addr,
   input  logic [DATA_W-1:0] m1_sram_wdata,
   input  logic              m1_sram_we_n,
   input  logic              m1_done,
   output logic              m1_start,
   input  logic [ADDR_W-1:0] vga_sram_addr,
   output logic              vga_enable,
   output logic [ADDR_W-1:0] sram_address,
   output logic [DATA_W-1:0] sram_write_data,
   output logic              sram_we_n,
   output logic [2:0]        stage,
   output logic              wd_error,
   output logic [31:0]       stage_cycles
);

   localparam int TW = $clog2(((UART_TIMEOUT > WD_CYCLES) ? UART_TIMEOUT : WD_CYCLES) + 1);
   localparam logic [TW-1:0] UART_LAST = TW'(UART_TIMEOUT - 1);
   localparam logic [TW-1:0] WD_LAST   = TW'(WD_CYCLES - 1);

   seq_state_t  state_q, state_d;
   logic        vga_enable_q, vga_enable_d;
   logic        uart_init_q, uart_init_d;
   logic        uart_enable_q, uart_enable_d;
   logic        m2_start_q, m2_start_d;
   logic        m1_start_q, m1_start_d;
   logic        wd_error_q, wd_error_d;
   logic        timer_clr_s, timer_en_s, timer_eq_s, first_cycle_s;
   logic [TW-1:0] timer_cmp_s, timer_cnt_s;
   sram_owner_t owner_s;

   // The UART phase compares against its idle limit, milestones against the watchdog.
   always_comb begin
      if (state_q == S_UART_RX) begin
         timer_cmp_s = UART_LAST;
      end else begin
         timer_cmp_s = WD_LAST;
      end
   end

   seq_timer #(.W(TW)) u_timer (
      .CLOCK_50_I (CLOCK_50_I),
      .resetn     (resetn),
      .clr_i      (timer_clr_s),
      .load_i     (1'b0),
      .load_val_i ({TW{1'b0}}),
      .en_i       (timer_en_s),
      .cmp_val_i  (timer_cmp_s),
      .count_o    (timer_cnt_s),
      .eq_o       (timer_eq_s)
   );

   // Timer is zeroed on stage entry and never wraps, so zero marks the first stage cycle.
   assign first_cycle_s = (timer_cnt_s == {TW{1'b0}});

   // Next state, control outputs and timer control.
   always_comb begin
      state_d       = state_q;
      vga_enable_d  = vga_enable_q;
      uart_init_d   = uart_init_q;
      uart_enable_d = uart_enable_q;
      m2_start_d    = m2_start_q;
      m1_start_d    = m1_start_q;
      wd_error_d    = wd_error_q;
      timer_clr_s   = 1'b0;
      timer_en_s    = 1'b0;
      case (state_q)
         S_IDLE: begin
            vga_enable_d = 1'b1;
            if (!UART_RX_I) begin
               uart_init_d  = 1'b1;
               vga_enable_d = 1'b0;
               wd_error_d   = 1'b0;
               timer_clr_s  = 1'b1;
               state_d      = S_UART_RX;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_UART_RX: begin
            uart_init_d   = 1'b0;
            uart_enable_d = 1'b1;
            if (!uart_sram_we_n) begin
               timer_clr_s = 1'b1;
            end else if (timer_eq_s) begin
               uart_enable_d = 1'b0;
               state_d       = S_HAND_A;
            end else begin
               timer_en_s = 1'b1;
            end
         end
         S_HAND_A: begin
            m2_start_d  = 1'b1;
            timer_clr_s = 1'b1;
            state_d     = S_M2;
         end
         S_M2: begin
            if (!first_cycle_s && m2_done) begin
               m2_start_d = 1'b0;
               state_d    = S_HAND_B;
            end else if (timer_eq_s) begin
               m2_start_d   = 1'b0;
               wd_error_d   = 1'b1;
               vga_enable_d = 1'b1;
               state_d      = S_IDLE;
            end else begin
               timer_en_s = 1'b1;
            end
         end
         S_HAND_B: begin
            m1_start_d  = 1'b1;
            timer_clr_s = 1'b1;
            state_d     = S_M1;
         end
         S_M1: begin
            if (!first_cycle_s && m1_done) begin
               m1_start_d   = 1'b0;
               vga_enable_d = 1'b1;
               state_d      = S_IDLE;
            end else if (timer_eq_s) begin
               m1_start_d   = 1'b0;
               wd_error_d   = 1'b1;
               vga_enable_d = 1'b1;
               state_d      = S_IDLE;
            end else begin
               timer_en_s = 1'b1;
            end
         end
         default: begin
            vga_enable_d  = 1'b1;
            uart_init_d   = 1'b0;
            uart_enable_d = 1'b0;
            m2_start_d    = 1'b0;
            m1_start_d    = 1'b0;
            state_d       = S_IDLE;
         end
      endcase
   end

   // State and control output registers.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         vga_enable_q  <= 1'b1;
         uart_init_q   <= 1'b0;
         uart_enable_q <= 1'b0;
         m2_start_q    <= 1'b0;
         m1_start_q    <= 1'b0;
         wd_error_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         vga_enable_q  <= vga_enable_d;
         uart_init_q   <= uart_init_d;
         uart_enable_q <= uart_enable_d;
         m2_start_q    <= m2_start_d;
         m1_start_q    <= m1_start_d;
         wd_error_q    <= wd_error_d;
      end
   end

   assign owner_s = owner_of(state_q);

   // SRAM port steering from the registered state; non-owner states only read for VGA.
   always_comb begin
      sram_address    = vga_sram_addr;
      sram_write_data = {DATA_W{1'b0}};
      sram_we_n       = 1'b1;
      case (owner_s)
         OWN_UART: begin
            sram_address    = uart_sram_addr;
            sram_write_data = uart_sram_wdata;
            sram_we_n       = uart_sram_we_n;
         end
         OWN_M2: begin
            sram_address    = m2_sram_addr;
            sram_write_data = m2_sram_wdata;
            sram_we_n       = m2_sram_we_n;
         end
         OWN_M1: begin
            sram_address    = m1_sram_addr;
            sram_write_data = m1_sram_wdata;
            sram_we_n       = m1_sram_we_n;
         end
         default: begin
            sram_address    = vga_sram_addr;
            sram_write_data = {DATA_W{1'b0}};
            sram_we_n       = 1'b1;
         end
      endcase
   end

`ifdef STAGE_CYCLE_COUNT_EN
   logic [31:0] stage_cnt_q, stage_cnt_d;
   logic [31:0] stage_cycles_q, stage_cycles_d;
   logic        stage_end_s;

   // A normal exit is M2 into its handover, or M1 home without a watchdog abort.
   assign stage_end_s = ((state_q == S_M2) && (state_d == S_HAND_B)) ||
                        ((state_q == S_M1) && (state_d == S_IDLE) && !wd_error_d);

   // Stage counter zeroed during the handover before each milestone, saturating while it runs.
   always_comb begin
      stage_cnt_d    = stage_cnt_q;
      stage_cycles_d = stage_cycles_q;
      if ((state_q == S_HAND_A) || (state_q == S_HAND_B)) begin
         stage_cnt_d = 32'd0;
      end else if (((state_q == S_M2) || (state_q == S_M1)) && (stage_cnt_q != 32'hFFFF_FFFF)) begin
         stage_cnt_d = stage_cnt_q + 32'd1;
      end else begin
         stage_cnt_d = stage_cnt_q;
      end
      if (stage_end_s) begin
         stage_cycles_d = stage_cnt_q;
      end else begin
         stage_cycles_d = stage_cycles_q;
      end
   end

   // Stage counter and latched result registers.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         stage_cnt_q    <= 32'd0;
         stage_cycles_q <= 32'd0;
      end else begin
         stage_cnt_q    <= stage_cnt_d;
         stage_cycles_q <= stage_cycles_d;
      end
   end

   assign stage_cycles = stage_cycles_q;
`else
   assign stage_cycles = 32'd0;
`endif

   assign stage       = state_q;
   assign vga_enable  = vga_enable_q;
   assign uart_init   = uart_init_q;
   assign uart_enable = uart_enable_q;
   assign m2_start    = m2_start_q;
   assign m1_start    = m1_start_q;
   assign wd_error    = wd_error_q;

endmodule

// File: tb/tb_decode_flow_sequencer.sv
// Self-checking bench for decode_flow_sequencer with shortened timeouts.
// Expected timing comes from the flow rules: exit edge counts relative to the
// last UART write or stage start, and the port owner implied by the phase.
module tb_decode_flow_sequencer;

   localparam int UART_TIMEOUT = 100;
   localparam int WD_CYCLES    = 1000;
   localparam int ADDR_W       = 18;
   localparam int DATA_W       = 16;

   logic              CLOCK_50_I;
   logic              resetn;
   logic              UART_RX_I;
   logic [ADDR_W-1:0] uart_sram_addr, m2_sram_addr, m1_sram_addr, vga_sram_addr, sram_address;
   logic [DATA_W-1:0] uart_sram_wdata, m2_sram_wdata, m1_sram_wdata, sram_write_data;
   logic              uart_sram_we_n, m2_sram_we_n, m1_sram_we_n, sram_we_n;
   logic              uart_init, uart_enable, m2_done, m2_start, m1_done, m1_start;
   logic              vga_enable, wd_error;
   logic [2:0]        stage;
   logic [31:0]       stage_cycles;

   int          cmp_count = 0;
   int          err_count = 0;
   int          cyc = 0;
   logic [31:0] exp_sc = 32'd0;

   decode_flow_sequencer #(
      .UART_TIMEOUT (UART_TIMEOUT),
      .WD_CYCLES    (WD_CYCLES),
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W)
   ) dut (
      .CLOCK_50_I      (CLOCK_50_I),
      .resetn          (resetn),
      .UART_RX_I       (UART_RX_I),
      .uart_sram_addr  (uart_sram_addr),
      .uart_sram_wdata (uart_sram_wdata),
      .uart_sram_we_n  (uart_sram_we_n),
      .uart_init       (uart_init),
      .uart_enable     (uart_enable),
      .m2_sram_addr    (m2_sram_addr),
      .m2_sram_wdata   (m2_sram_wdata),
      .m2_sram_we_n    (m2_sram_we_n),
      .m2_done         (m2_done),
      .m2_start        (m2_start),
      .m1_sram_addr    (m1_sram_addr),
      .m1_sram_wdata   (m1_sram_wdata),
      .m1_sram_we_n    (m1_sram_we_n),
      .m1_done         (m1_done),
      .m1_start        (m1_start),
      .vga_sram_addr   (vga_sram_addr),
      .vga_enable      (vga_enable),
      .sram_address    (sram_address),
      .sram_write_data (sram_write_data),
      .sram_we_n       (sram_we_n),
      .stage           (stage),
      .wd_error        (wd_error),
      .stage_cycles    (stage_cycles)
   );

   initial CLOCK_50_I = 1'b0;
   always #10 CLOCK_50_I = ~CLOCK_50_I;

   always @(posedge CLOCK_50_I) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish before time limit");
      $fatal(1, "time limit");
   end

   task automatic step();
      @(posedge CLOCK_50_I);
      #1;
   endtask

   task automatic rand_reqs();
      uart_sram_addr  = ADDR_W'($urandom);
      uart_sram_wdata = DATA_W'($urandom);
      m2_sram_addr    = ADDR_W'($urandom);
      m2_sram_wdata   = DATA_W'($urandom);
      m2_sram_we_n    = 1'($urandom);
      m1_sram_addr    = ADDR_W'($urandom);
      m1_sram_wdata   = DATA_W'($urandom);
      m1_sram_we_n    = 1'($urandom);
      vga_sram_addr   = ADDR_W'($urandom);
   endtask

   task automatic test_reset();
      resetn = 1'b0; UART_RX_I = 1'b1; m2_done = 1'b0; m1_done = 1'b0;
      rand_reqs(); uart_sram_we_n = 1'b0; m1_sram_we_n = 1'b0; m2_sram_we_n = 1'b0;
      repeat (3) step();
      cmp_count++;
      if ({stage, vga_enable, uart_init, uart_enable, m2_start, m1_start, wd_error} !== 9'b000_1_00000) begin
         err_count++;
         $display("FAIL reset_outputs: got %b expected %b",
                  {stage, vga_enable, uart_init, uart_enable, m2_start, m1_start, wd_error}, 9'b000_1_00000);
      end
      cmp_count++;
      if (stage_cycles !== 32'd0) begin
         err_count++; $display("FAIL reset_stage_cycles: got %0d expected 0", stage_cycles);
      end
      cmp_count++;
      if ({sram_address, sram_write_data, sram_we_n} !== {vga_sram_addr, 16'h0000, 1'b1}) begin
         err_count++;
         $display("FAIL reset_mux: got %h expected %h", {sram_address, sram_write_data, sram_we_n},
                  {vga_sram_addr, 16'h0000, 1'b1});
      end
      resetn = 1'b1;
      step();
   endtask

   task automatic test_uart_rx(input int nwrites, input int gap);
      int last_w;
      int n;
      int init_seen;
      int vga_seen;
      init_seen = 0; vga_seen = 0; last_w = 0;
      uart_sram_we_n = 1'b1;
      repeat ($urandom_range(2, 6)) begin
         UART_RX_I = 1'b1; rand_reqs(); #1;
         cmp_count++;
         if ({stage, vga_enable} !== {3'd0, 1'b1}) begin
            err_count++; $display("FAIL idle_hold: got %b expected %b", {stage, vga_enable}, {3'd0, 1'b1});
         end
         cmp_count++;
         if ({sram_address, sram_write_data, sram_we_n} !== {vga_sram_addr, 16'h0000, 1'b1}) begin
            err_count++;
            $display("FAIL idle_mux: got %h expected %h", {sram_address, sram_write_data, sram_we_n},
                     {vga_sram_addr, 16'h0000, 1'b1});
         end
         step();
      end
      UART_RX_I = 1'b0;
      step();
      cmp_count++;
      if ({stage, uart_init, vga_enable, wd_error} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
         err_count++;
         $display("FAIL uart_start: got %b expected %b", {stage, uart_init, vga_enable, wd_error}, 6'b001_1_0_0);
      end
      UART_RX_I = 1'($urandom);
      step();
      cmp_count++;
      if ({uart_init, uart_enable} !== 2'b01) begin
         err_count++; $display("FAIL uart_init_pulse: got %b expected 01", {uart_init, uart_enable});
      end
      for (int w = 0; w < nwrites; w++) begin
         n = (gap > 0) ? (gap - 1) : int'($urandom_range(0, 29));
         for (int k = 0; k <= n; k++) begin
            UART_RX_I = 1'($urandom); rand_reqs();
            uart_sram_we_n = (k == n) ? 1'b0 : 1'b1;
            #1;
            cmp_count++;
            if ({sram_address, sram_write_data, sram_we_n} !== {uart_sram_addr, uart_sram_wdata, uart_sram_we_n}) begin
               err_count++;
               $display("FAIL uart_mux: got %h expected %h", {sram_address, sram_write_data, sram_we_n},
                        {uart_sram_addr, uart_sram_wdata, uart_sram_we_n});
            end
            if (k == n) last_w = cyc + 1;
            step();
            if (uart_init) init_seen++;
            if (vga_enable) vga_seen++;
         end
      end
      uart_sram_we_n = 1'b1;
      for (int k = 0; (k < 3 * UART_TIMEOUT) && (stage == 3'd1); k++) begin
         UART_RX_I = 1'($urandom); rand_reqs(); #1;
         cmp_count++;
         if ({sram_address, sram_write_data, sram_we_n} !== {uart_sram_addr, uart_sram_wdata, 1'b1}) begin
            err_count++;
            $display("FAIL uart_idle_mux: got %h expected %h", {sram_address, sram_write_data, sram_we_n},
                     {uart_sram_addr, uart_sram_wdata, 1'b1});
         end
         step();
         if (uart_init) init_seen++;
         if (vga_enable) vga_seen++;
      end
      cmp_count++;
      if ({stage, uart_enable} !== {3'd2, 1'b0}) begin
         err_count++; $display("FAIL uart_exit_state: got %b expected %b", {stage, uart_enable}, 4'b010_0);
      end
      cmp_count++;
      if (cyc - last_w != UART_TIMEOUT) begin
         err_count++; $display("FAIL uart_timeout_len: got %0d expected %0d", cyc - last_w, UART_TIMEOUT);
      end
      cmp_count++;
      if ((init_seen != 0) || (vga_seen != 0)) begin
         err_count++;
         $display("FAIL uart_phase_flags: got init=%0d vga=%0d cycles expected 0 and 0", init_seen, vga_seen);
      end
   endtask

   // Entered while the handover state before the stage is visible.
   task automatic run_stage(input int which, input int done_cycle);
      int          exit_cycle;
      bit          normal;
      logic [2:0]  code;
      logic [2:0]  hand_code;
      logic [2:0]  exp_stage;
      logic [4:0]  exp_post;
      code      = (which == 2) ? 3'd3 : 3'd5;
      hand_code = (which == 2) ? 3'd2 : 3'd4;
      normal     = (done_cycle >= 0) && (((done_cycle < 1) ? 1 : done_cycle) <= WD_CYCLES - 1);
      exit_cycle = normal ? ((done_cycle < 1) ? 1 : done_cycle) : (WD_CYCLES - 1);
      rand_reqs(); m1_sram_we_n = 1'b0; m2_sram_we_n = 1'b0; uart_sram_we_n = 1'b0;
      UART_RX_I = 1'($urandom);
      if (which == 2) m2_done = (done_cycle == 0); else m1_done = (done_cycle == 0);
      #1;
      cmp_count++;
      if (stage !== hand_code) begin
         err_count++; $display("FAIL handover_state: got %0d expected %0d", stage, hand_code);
      end
      cmp_count++;
      if ({sram_address, sram_write_data, sram_we_n} !== {vga_sram_addr, 16'h0000, 1'b1}) begin
         err_count++;
         $display("FAIL handover_mux: got %h expected %h", {sram_address, sram_write_data, sram_we_n},
                  {vga_sram_addr, 16'h0000, 1'b1});
      end
      uart_sram_we_n = 1'b1;
      step();
      for (int i = 0; i <= exit_cycle; i++) begin
         cmp_count++;
         if ({stage, m2_start, m1_start} !== {code, (which == 2), (which == 1)}) begin
            err_count++;
            $display("FAIL stage_run cycle %0d: got %b expected %b", i, {stage, m2_start, m1_start},
                     {code, (which == 2), (which == 1)});
         end
         rand_reqs(); UART_RX_I = 1'($urandom);
         if (which == 2) m2_done = (done_cycle >= 0) && (i >= done_cycle);
         else            m1_done = (done_cycle >= 0) && (i >= done_cycle);
         #1;
         cmp_count++;
         if (which == 2) begin
            if ({sram_address, sram_write_data, sram_we_n} !== {m2_sram_addr, m2_sram_wdata, m2_sram_we_n}) begin
               err_count++;
               $display("FAIL m2_mux: got %h expected %h", {sram_address, sram_write_data, sram_we_n},
                        {m2_sram_addr, m2_sram_wdata, m2_sram_we_n});
            end
         end else begin
            if ({sram_address, sram_write_data, sram_we_n} !== {m1_sram_addr, m1_sram_wdata, m1_sram_we_n}) begin
               err_count++;
               $display("FAIL m1_mux: got %h expected %h", {sram_address, sram_write_data, sram_we_n},
                        {m1_sram_addr, m1_sram_wdata, m1_sram_we_n});
            end
         end
         step();
      end
      UART_RX_I = 1'b1; m2_done = 1'b0; m1_done = 1'b0;
      if (normal) begin
`ifdef STAGE_CYCLE_COUNT_EN
         exp_sc = 32'(exit_cycle);
`else
         exp_sc = 32'd0;
`endif
      end
      exp_stage = (normal && (which == 2)) ? 3'd4 : 3'd0;
      exp_post  = {exp_stage, !normal, !(normal && (which == 2))};
      cmp_count++;
      if ({stage, wd_error, vga_enable} !== exp_post || {m2_start, m1_start} !== 2'b00) begin
         err_count++;
         $display("FAIL stage_exit: got %b starts %b expected %b starts 00", {stage, wd_error, vga_enable},
                  {m2_start, m1_start}, exp_post);
      end
      cmp_count++;
      if (stage_cycles !== exp_sc) begin
         err_count++; $display("FAIL stage_cycles: got %0d expected %0d", stage_cycles, exp_sc);
      end
   endtask

   // Entered with the M2->M1 handover visible; resets part-way through M1.
   task automatic test_reset_mid_m1();
      m1_sram_we_n = 1'b0;
      step();
      repeat ($urandom_range(2, 10)) begin
         rand_reqs(); m1_sram_we_n = 1'b0; m1_done = 1'b0; #1;
         cmp_count++;
         if ({stage, sram_address, sram_we_n} !== {3'd5, m1_sram_addr, 1'b0}) begin
            err_count++;
            $display("FAIL m1_pre_reset: got %h expected %h", {stage, sram_address, sram_we_n},
                     {3'd5, m1_sram_addr, 1'b0});
         end
         step();
      end
      rand_reqs(); m1_sram_we_n = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      cmp_count++;
      if ({stage, vga_enable, uart_init, uart_enable, m2_start, m1_start, wd_error, sram_we_n} !== 10'b000_1_00000_1) begin
         err_count++;
         $display("FAIL async_reset: got %b expected %b",
                  {stage, vga_enable, uart_init, uart_enable, m2_start, m1_start, wd_error, sram_we_n}, 10'b000_1_00000_1);
      end
      cmp_count++;
      if ({sram_address, stage_cycles} !== {vga_sram_addr, 32'd0}) begin
         err_count++;
         $display("FAIL async_reset_mux: got %h expected %h", {sram_address, stage_cycles}, {vga_sram_addr, 32'd0});
      end
      exp_sc = 32'd0;
      step();
      resetn = 1'b1;
      step();
   endtask

   initial begin
      resetn = 1'b0; UART_RX_I = 1'b1; m2_done = 1'b0; m1_done = 1'b0;
      uart_sram_we_n = 1'b1; rand_reqs();
      test_reset();
      test_uart_rx(5, 10);
      run_stage(2, 50);
      run_stage(1, -1);
      test_uart_rx(4, 0);
      run_stage(2, 0);
      run_stage(1, WD_CYCLES - 1);
      test_uart_rx(3, 0);
      run_stage(2, int'($urandom_range(2, 80)));
      test_reset_mid_m1();
      test_uart_rx(2, 0);
      run_stage(2, int'($urandom_range(1, 40)));
      run_stage(1, int'($urandom_range(1, 40)));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule

// File: doc/decode_flow_sequencer.md
Name: decode_flow_sequencer

Overview:
- Top-level scheduler for the image decompressor.
- Sequences the flow IDLE → UART receive → milestone 2 → milestone 1 → IDLE.
- Owns the single SRAM controller port and grants it to one requester at a time: UART, M2, M1, or VGA by default.
- Adds a one-cycle bus handover between owners, a per-stage watchdog, and a sticky error flag.

Parameters:
- UART_TIMEOUT, 50000000: idle cycles on UART writes before the receive phase is considered finished.
- WD_CYCLES, 67108863: maximum cycles a milestone stage may run before it is aborted.
- ADDR_W, 18: SRAM address width.
- DATA_W, 16: SRAM data width.

Ports:
- CLOCK_50_I  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous, active-low reset
- UART_RX_I  in  1  raw UART line; low means a start bit
- uart_sram_addr  in  ADDR_W  UART-interface SRAM address
- uart_sram_wdata  in  DATA_W  UART-interface write data
- uart_sram_we_n  in  1  UART-interface write enable, active low
- uart_init  out  1  UART interface initialize pulse
- uart_enable  out  1  UART interface enable
- m2_sram_addr / m2_sram_wdata / m2_sram_we_n  in  ADDR_W / DATA_W / 1  M2 SRAM request
- m2_done  in  1  M2 completion
- m2_start  out  1  M2 run level
- m1_sram_addr / m1_sram_wdata / m1_sram_we_n  in  ADDR_W / DATA_W / 1  M1 SRAM request
- m1_done  in  1  M1 completion
- m1_start  out  1  M1 run level
- vga_sram_addr  in  ADDR_W  VGA read address
- vga_enable  out  1  VGA fetch enable
- sram_address  out  ADDR_W  to SRAM controller
- sram_write_data  out  DATA_W  to SRAM controller
- sram_we_n  out  1  to SRAM controller
- stage  out  3  current state code, for LEDs and debug
- wd_error  out  1  sticky watchdog abort flag
- stage_cycles  out  32  cycles of the last completed milestone stage (optional feature)

Behaviour:
- Reset is asynchronous, resetn active low, clock CLOCK_50_I.
- Reset values: state S_IDLE, vga_enable=1, uart_init=0, uart_enable=0, m2_start=0, m1_start=0, wd_error=0, timer=0, stage_cycles=0.
- Reset mid-operation aborts any stage immediately. The SRAM mux falls to VGA, so sram_we_n=1.
- States and codes:
  - S_IDLE (0): vga_enable=1. UART_RX_I==0 → uart_init=1, vga_enable=0, timer=0, wd_error=0, go to S_UART_RX.
  - S_UART_RX (1): uart_init drops after 1 cycle; uart_enable=1 from the following cycle onward. Timer increments each cycle and is cleared on any cycle with uart_sram_we_n==0. Timer==UART_TIMEOUT-1 → uart_enable=0, go to S_HAND_A.
  - S_HAND_A (2): exactly 1 cycle. Next state S_M2, m2_start=1.
  - S_M2 (3): m2_start held high. m2_done is ignored on the first cycle of the stage. From the second cycle on, m2_done=1 → m2_start=0, go to S_HAND_B.
  - S_HAND_B (4): exactly 1 cycle. Next state S_M1, m1_start=1.
  - S_M1 (5): mirrors S_M2 using m1 signals. Exit goes to S_IDLE with vga_enable=1.
- Watchdog:
  - Timer clears on entry to S_M2 and S_M1.
  - Reaching WD_CYCLES-1 without the done signal → deassert the start signal, set wd_error=1, go to S_IDLE.
  - wd_error stays set until the next UART start bit.
- SRAM mux (combinational on the registered state):
  - S_UART_RX → UART requester.
  - S_M2 → M2 requester.
  - S_M1 → M1 requester.
  - All other states → address=vga_sram_addr, data=0, we_n=1.
  - Handover states therefore never write, which guarantees no write overlap between owners.
- UART_RX_I activity outside S_IDLE is ignored.
- done and timeout on the same cycle: done wins, and wd_error stays 0.
- Timer width is $clog2(max(UART_TIMEOUT, WD_CYCLES)+1). The timer saturates and never wraps.

Optional Feature:
- Macro: STAGE_CYCLE_COUNT_EN.
- Defined: a 32-bit counter clears on entry to S_M2 and S_M1 and increments while in the stage. On normal exit its value is latched into stage_cycles, which holds until the next latch. The counter saturates at 32'hFFFFFFFF.
- Undefined: no counter logic is built, and stage_cycles is tied to 0.

Decomposition:
- Shared package seq_pkg holds:
  - state enum seq_state_t (3-bit, codes as above);
  - mux-select enum sram_owner_t {OWN_VGA, OWN_UART, OWN_M2, OWN_M1};
  - default parameter constants.
- One sub-module, seq_timer: loadable saturating counter with clear, enable, and compare-equal output. It is shared between the UART timeout and the watchdog roles.

Test Plan:
- UART_TIMEOUT=100. Drive UART_RX_I=0 in S_IDLE, then 5 writes 10 cycles apart, then silence → uart_init is 1 for exactly 1 cycle, state leaves S_UART_RX exactly 100 cycles after the last write, and vga_enable=0 throughout.
- m2_done asserted 50 cycles after m2_start → S_HAND_B lasts 1 cycle with sram_we_n=1, then m1_start=1. With STAGE_CYCLE_COUNT_EN defined, stage_cycles=50.
- WD_CYCLES=1000, m1_done never asserted → after 1000 cycles m1_start=0, wd_error=1, state S_IDLE. The next UART start clears wd_error.
- m2_done held high before S_M2 entry → ignored on the first cycle, exits on the second cycle.
- resetn pulled low mid-S_M1 with m1_sram_we_n=0 → sram_we_n=1 and all outputs at reset values within the same cycle (asynchronous).
- UART_RX_I toggled while in S_M2 → no state change, and the mux stays on M2.
